// File: rtl/uart_pkg.sv
// UART shared definitions: transmitter states, parity modes and
// the parity helper used by both directions of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Data is zero-extended to 9 bits, so padding never affects the XOR.
  function automatic logic par_bit(
    input logic [8:0] d,
    input int         mode
  );
    return (^d) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/baud_edge_sync.sv
// Brings the divider output into the CLK domain and turns each of
// its rising edges into a single-cycle tick.
module baud_edge_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic BAUDCLK,
  output logic tick
);

  logic s1, s2, s3;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= BAUDCLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

endmodule

// File: rtl/uart_tx_baud.sv
// UART transmitter paced by an external bit-rate clock: one-entry
// holding register feeding a shift register and a framing FSM.
module uart_tx_baud
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 BAUDCLK,
  input  logic [DATA_BITS-1:0] DATA,
  input  logic                 VALID,
  output logic                 READY,
  output logic                 TX,
  output logic                 BUSY
);

  localparam logic [3:0] DB = 4'(DATA_BITS);
  localparam logic [1:0] SB = 2'(STOP_BITS);

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shift;
  logic                 hold_full;
  logic                 par;
  logic [3:0]           cnt;
  logic [1:0]           scnt;
  logic                 tick;
  logic                 last_stop;
  logic                 xfer;

  baud_edge_sync u_sync (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BAUDCLK (BAUDCLK),
    .tick    (tick)
  );

  assign last_stop = (state == TX_STOP)
                   & (scnt >= SB);
  assign xfer = tick & hold_full
              & ((state == TX_IDLE) | last_stop);

  assign READY = ~hold_full;
  assign BUSY  = (state != TX_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (VALID && !hold_full) begin
      hold      <= DATA;
      hold_full <= 1'b1;
    end else if (xfer) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= TX_IDLE;
      shift <= '0;
      par   <= 1'b0;
      cnt   <= '0;
      scnt  <= '0;
      TX    <= 1'b1;
    end else if (tick) begin
      unique case (state)
        TX_IDLE: begin
          if (xfer) begin
            shift <= hold;
            par   <= par_bit(9'(hold), PARITY);
            TX    <= 1'b0;
            state <= TX_START;
          end else begin
            TX <= 1'b1;
          end
        end
        TX_START: begin
          TX    <= shift[0];
          shift <= shift >> 1;
          cnt   <= 4'd1;
          state <= TX_DATA;
        end
        TX_DATA: begin
          if (cnt < DB) begin
            TX    <= shift[0];
            shift <= shift >> 1;
            cnt   <= cnt + 4'd1;
          end else if (PARITY != PARITY_NONE) begin
            TX    <= par;
            state <= TX_PAR;
          end else begin
            TX    <= 1'b1;
            scnt  <= 2'd1;
            state <= TX_STOP;
          end
        end
        TX_PAR: begin
          TX    <= 1'b1;
          scnt  <= 2'd1;
          state <= TX_STOP;
        end
        TX_STOP: begin
          if (scnt < SB) begin
            scnt <= scnt + 2'd1;
          end else if (xfer) begin
            // Next frame starts straight out of the stop bit.
            shift <= hold;
            par   <= par_bit(9'(hold), PARITY);
            TX    <= 1'b0;
            state <= TX_START;
          end else begin
            state <= TX_IDLE;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_baud.sv
// Bench for uart_tx_baud: three framing configurations driven in
// parallel, checked against a bit-stream model and fixed frames.
module tb_uart_tx_baud;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BAUDCLK = 1'b0;
  logic [7:0] data = '0;
  logic [2:0] valid = '0;
  logic [2:0] ready, tx, busy;

  int n_cmp = 0;
  int n_bad = 0;

  int par_cfg[3] = '{0, 1, 2};
  int stp_cfg[3] = '{1, 2, 1};

  logic [15:0] line_bits[3];
  int          line_n[3];
  logic        hold_v[3];
  logic [7:0]  hold_d[3];
  logic        cur_exp[3];
  logic        cur_busy[3];
  logic        last_tx[3];

  int   cyc = 0;
  int   ref_cyc = 0;
  bit   meas = 0;
  bit   have_ref = 0;
  logic prev_tx0 = 1'b1;

  always #5 CLK = ~CLK;

  uart_tx_baud #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .BAUDCLK(BAUDCLK), .DATA(data),
    .VALID(valid[0]), .READY(ready[0]), .TX(tx[0]), .BUSY(busy[0])
  );

  uart_tx_baud #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .BAUDCLK(BAUDCLK), .DATA(data),
    .VALID(valid[1]), .READY(ready[1]), .TX(tx[1]), .BUSY(busy[1])
  );

  uart_tx_baud #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .BAUDCLK(BAUDCLK), .DATA(data),
    .VALID(valid[2]), .READY(ready[2]), .TX(tx[2]), .BUSY(busy[2])
  );

  task automatic chk(input string nm, input int i,
                     input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %b want %b at %0t",
               nm, i, act, exp, $time);
    end
  endtask

  function automatic void mk_frame(input logic [7:0] d,
                                   input int par, input int stp,
                                   output logic [15:0] b,
                                   output int n);
    b = '0;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    n = 9;
    if (par != 0) begin
      b[n] = (^d) ^ (par == 2);
      n = n + 1;
    end
    for (int s = 0; s < stp; s++) begin
      b[n] = 1'b1;
      n = n + 1;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      line_bits[i] = '0;
      line_n[i]    = 0;
      hold_v[i]    = 1'b0;
      hold_d[i]    = '0;
      cur_exp[i]   = 1'b1;
      cur_busy[i]  = 1'b0;
    end
  endtask

  // One bit time: model advances at the rise, DUT checked mid-period,
  // VALID offered in the low half, optional reset pulse after that.
  task automatic baud_period(input logic [2:0] v,
                             input logic [7:0] d,
                             input bit rst_mid);
    BAUDCLK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (line_n[i] == 0 && hold_v[i]) begin
        mk_frame(hold_d[i], par_cfg[i], stp_cfg[i],
                 line_bits[i], line_n[i]);
        hold_v[i] = 1'b0;
      end
      if (line_n[i] > 0) begin
        cur_exp[i]   = line_bits[i][0];
        line_bits[i] = line_bits[i] >> 1;
        line_n[i]    = line_n[i] - 1;
        cur_busy[i]  = 1'b1;
      end else begin
        cur_exp[i]  = 1'b1;
        cur_busy[i] = 1'b0;
      end
    end
    repeat (10) @(negedge CLK);
    BAUDCLK = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tx", i, tx[i], cur_exp[i]);
      chk("busy", i, busy[i], cur_busy[i]);
      chk("ready", i, ready[i], ~hold_v[i]);
      last_tx[i] = tx[i];
    end
    valid = v;
    data  = d;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      if (v[i] && !hold_v[i]) begin
        hold_v[i] = 1'b1;
        hold_d[i] = d;
      end
    end
    valid = '0;
    data  = $urandom;
    if (rst_mid) begin
      RST_N = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
        chk("rst_tx", i, tx[i], 1'b1);
        chk("rst_busy", i, busy[i], 1'b0);
        chk("rst_ready", i, ready[i], 1'b1);
      end
      model_reset();
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (7) @(negedge CLK);
    end else begin
      repeat (9) @(negedge CLK);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (line_n[0] == 0 && line_n[1] == 0 && line_n[2] == 0 &&
          !hold_v[0] && !hold_v[1] && !hold_v[2]) break;
      baud_period(3'b000, 8'h00, 1'b0);
    end
  endtask

  // Bit-width check on the alternating frame: every edge 20 CLK apart.
  always @(negedge CLK) begin
    cyc++;
    if (!meas) begin
      have_ref = 0;
    end else if (tx[0] !== prev_tx0) begin
      if (have_ref) begin
        n_cmp++;
        if (cyc - ref_cyc != 20) begin
          n_bad++;
          $display("FAIL bit_len: got %0d clk want 20",
                   cyc - ref_cyc);
        end
      end
      ref_cyc  = cyc;
      have_ref = 1;
    end
    prev_tx0 = tx[0];
  end

  typedef struct {
    int          dut;
    logic [7:0]  d;
    logic [15:0] bits;
    int          len;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{0, 8'h55, 16'h02AA, 10};
    vt[1] = '{1, 8'h07, 16'h0E0E, 12};
    vt[2] = '{2, 8'h07, 16'h040E, 11};
    vt[3] = '{0, 8'hA5, 16'h034A, 10};
    vt[4] = '{1, 8'hFF, 16'h0DFE, 12};
    vt[5] = '{2, 8'h00, 16'h0600, 11};

    model_reset();
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      chk("init_tx", i, tx[i], 1'b1);
      chk("init_ready", i, ready[i], 1'b1);
      chk("init_busy", i, busy[i], 1'b0);
    end
    RST_N = 1'b1;
    @(negedge CLK);

    repeat (10) baud_period(3'b000, 8'h00, 1'b0);

    for (int v = 0; v < 6; v++) begin
      drain();
      meas = (v == 0);
      baud_period(3'(1 << vt[v].dut), vt[v].d, 1'b0);
      for (int k = 0; k < vt[v].len; k++) begin
        baud_period(3'b000, 8'h00, 1'b0);
        chk("vec_bit", vt[v].dut, last_tx[vt[v].dut],
            vt[v].bits[k]);
      end
      baud_period(3'b000, 8'h00, 1'b0);
      chk("vec_idle", vt[v].dut, last_tx[vt[v].dut], 1'b1);
      meas = 0;
    end

    drain();
    baud_period(3'b001, 8'hA5, 1'b0);
    baud_period(3'b001, 8'h3C, 1'b0);
    chk("b2b_ready", 0, ready[0], 1'b0);
    drain();

    baud_period(3'b111, 8'h11, 1'b0);
    baud_period(3'b111, 8'h22, 1'b0);
    baud_period(3'b111, 8'h33, 1'b0);
    baud_period(3'b111, 8'h44, 1'b0);
    drain();

    baud_period(3'b001, 8'hEF, 1'b0);
    repeat (5) baud_period(3'b000, 8'h00, 1'b0);
    baud_period(3'b000, 8'h00, 1'b1);
    baud_period(3'b111, 8'h5A, 1'b0);
    drain();

    for (int r = 0; r < 150; r++) begin
      baud_period(3'($urandom_range(0, 7)), 8'($urandom), 1'b0);
    end
    drain();
    repeat (2) baud_period(3'b000, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
